// File: rtl/overture_stack_core.sv
// Overture stack core: single-cycle 8-bit-opcode accumulator machine with
// a return-address stack and valid/ready I/O through the COPY instruction.
module overture_stack_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   prog_addr,
    input  logic [7:0]            prog_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  halted,
    output logic                  stack_err
);

    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IW;

    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   pc_next;
    logic [PC_WIDTH-1:0]   r0_target;
    logic [DATA_WIDTH-1:0] regs [6];
    logic [PC_WIDTH-1:0]   stack [SLOTS];
    logic [SPW-1:0]        sp;
    logic [SPW-1:0]        sp_next;
    logic                  halted_next;
    logic                  err_next;

    logic [1:0] mode;
    logic [2:0] src;
    logic [2:0] op;
    logic       is_imm;
    logic       is_calc;
    logic       is_copy;
    logic       is_cond;
    logic       is_halt;
    logic       is_call;
    logic       is_ret;
    logic       stack_full;
    logic       stack_empty;

    logic [DATA_WIDTH-1:0] src_val;
    logic [DATA_WIDTH-1:0] calc_val;
    logic [DATA_WIDTH-1:0] wr_val;
    logic                  wr_en;
    logic [2:0]            wr_idx;
    logic                  io_done;
    logic                  cond_true;
    logic                  push;
    logic                  r3_zero;
    logic                  r3_neg;
    logic [IW-1:0]         push_idx;
    logic [IW-1:0]         pop_idx;

    assign mode    = prog_data[7:6];
    assign src     = prog_data[5:3];
    assign op      = prog_data[2:0];
    assign is_imm  = (mode == 2'b00);
    assign is_calc = (mode == 2'b01);
    assign is_copy = (mode == 2'b10);
    assign is_cond = (mode == 2'b11);
    assign is_halt = is_copy && (src == 3'd7) && (op == 3'd7);
    assign is_call = is_calc && (op == 3'd6);
    assign is_ret  = is_calc && (op == 3'd7);

    assign prog_addr   = pc;
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = IW'(sp);
    assign pop_idx     = IW'(sp - SPW'(1));

    // Jump targets come from r0, truncated or zero-extended to the PC width
    if (PC_WIDTH <= DATA_WIDTH) begin : g_tgt_trunc
        assign r0_target = regs[0][PC_WIDTH-1:0];
    end else begin : g_tgt_ext
        assign r0_target = {{(PC_WIDTH - DATA_WIDTH){1'b0}}, regs[0]};
    end

    always_comb begin
        src_val = '0;
        case (src)
            3'd6:    src_val = in_data;
            3'd7:    src_val = '0;
            default: src_val = regs[src];
        endcase
    end

    always_comb begin
        calc_val = '0;
        case (op)
            3'd0:    calc_val = regs[1] | regs[2];
            3'd1:    calc_val = ~(regs[1] & regs[2]);
            3'd2:    calc_val = ~(regs[1] | regs[2]);
            3'd3:    calc_val = regs[1] & regs[2];
            3'd4:    calc_val = regs[1] + regs[2];
            3'd5:    calc_val = regs[1] - regs[2];
            default: calc_val = '0;
        endcase
    end

    assign r3_zero = (regs[3] == '0);
    assign r3_neg  = regs[3][DATA_WIDTH-1];

    always_comb begin
        cond_true = 1'b0;
        case (op)
            3'd0: cond_true = 1'b0;
            3'd1: cond_true = r3_zero;
            3'd2: cond_true = r3_neg;
            3'd3: cond_true = r3_neg || r3_zero;
            3'd4: cond_true = 1'b1;
            3'd5: cond_true = !r3_zero;
            3'd6: cond_true = !r3_neg;
            3'd7: cond_true = !r3_neg && !r3_zero;
            default: cond_true = 1'b0;
        endcase
    end

    // Handshakes are purely combinational; reset and halt mask them
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (is_copy && !halted && !rst) begin
            in_ready  = (src == 3'd6) && ((op != 3'd6) || out_ready);
            out_valid = (op == 3'd6) && ((src != 3'd6) || in_valid);
            out_data  = out_valid ? src_val : '0;
        end
    end

    assign io_done = ((src != 3'd6) || (in_valid && in_ready)) &&
                     ((op != 3'd6) || (out_valid && out_ready));

    always_comb begin
        pc_next     = pc;
        sp_next     = sp;
        err_next    = stack_err;
        halted_next = halted;
        push        = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = op;
        wr_val      = src_val;
        if (!halted) begin
            unique case (1'b1)
                is_imm: begin
                    wr_en   = 1'b1;
                    wr_idx  = 3'd0;
                    wr_val  = DATA_WIDTH'(prog_data[5:0]);
                    pc_next = pc_inc;
                end
                is_calc: begin
                    pc_next = pc_inc;
                    if (is_call) begin
                        if (stack_full) begin
                            err_next = 1'b1;
                        end else begin
                            push    = 1'b1;
                            sp_next = sp + SPW'(1);
                            pc_next = r0_target;
                        end
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            err_next = 1'b1;
                        end else begin
                            sp_next = sp - SPW'(1);
                            pc_next = stack[pop_idx];
                        end
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = 3'd3;
                        wr_val = calc_val;
                    end
                end
                is_copy: begin
                    if (is_halt) begin
                        halted_next = 1'b1;
                    end else if (io_done) begin
                        wr_en   = (op < 3'd6);
                        wr_idx  = op;
                        wr_val  = src_val;
                        pc_next = pc_inc;
                    end
                end
                is_cond: begin
                    pc_next = cond_true ? r0_target : pc_inc;
                end
                default: begin
                    pc_next = pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            sp        <= '0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc        <= pc_next;
            sp        <= sp_next;
            halted    <= halted_next;
            stack_err <= err_next;
            if (wr_en) begin
                regs[wr_idx] <= wr_val;
            end
        end
    end

    // Stack storage needs no reset: entries above sp are never read
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_overture_stack_core.sv
// Bench for overture_stack_core: directed scenarios plus random programs,
// every cycle compared against a queue-based behavioural model.
module tb_overture_stack_core;

    localparam int DW    = 8;
    localparam int PW    = 8;
    localparam int SD    = 2;
    localparam int MASK  = (1 << DW) - 1;
    localparam int PMASK = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          halted;
    logic          stack_err;

    logic [7:0] rom [256];
    assign prog_data = rom[prog_addr];

    int n_chk  = 0;
    int n_fail = 0;
    int xfers  = 0;

    int m_pc;
    int m_r [6];
    int m_stk [$];
    bit m_halt;
    bit m_err;

    overture_stack_core #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .halted   (halted),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(int v);
        return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
    endfunction

    task automatic model_reset();
        m_pc = 0;
        foreach (m_r[k]) m_r[k] = 0;
        m_stk.delete();
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock: entered just after a falling edge with inputs driven
    task automatic tick();
        int ins, mode, src, dst, v, s, r1, r2;
        bit e_ir, e_ov, done, take;
        int e_od;
        #1;
        ins  = int'(rom[m_pc]);
        mode = ins >> 6;
        src  = (ins >> 3) & 7;
        dst  = ins & 7;
        e_ir = !rst && !m_halt && mode == 2 && src == 6 && (dst != 6 || out_ready);
        e_ov = !rst && !m_halt && mode == 2 && dst == 6 && (src != 6 || in_valid);
        v    = (src < 6) ? m_r[src] : ((src == 6) ? int'(in_data) : 0);
        e_od = e_ov ? v : 0;
        check("pc", 32'(prog_addr), 32'(m_pc));
        check("in_ready", 32'(in_ready), 32'(e_ir));
        check("out_valid", 32'(out_valid), 32'(e_ov));
        check("out_data", 32'(out_data), 32'(e_od));
        check("halted", 32'(halted), 32'(m_halt));
        check("stack_err", 32'(stack_err), 32'(m_err));
        if (out_valid && out_ready) xfers++;
        if (rst) begin
            model_reset();
        end else if (!m_halt) begin
            r1 = m_r[1];
            r2 = m_r[2];
            case (mode)
                0: begin
                    m_r[0] = ins & 63;
                    m_pc++;
                end
                1: begin
                    case (dst)
                        0: m_r[3] = r1 | r2;
                        1: m_r[3] = ~(r1 & r2) & MASK;
                        2: m_r[3] = ~(r1 | r2) & MASK;
                        3: m_r[3] = r1 & r2;
                        4: m_r[3] = (r1 + r2) & MASK;
                        5: m_r[3] = (r1 - r2) & MASK;
                        default: ;
                    endcase
                    if (dst == 6) begin
                        if (m_stk.size() == SD) begin
                            m_err = 1'b1;
                            m_pc++;
                        end else begin
                            m_stk.push_back((m_pc + 1) & PMASK);
                            m_pc = m_r[0] & PMASK;
                        end
                    end else if (dst == 7) begin
                        if (m_stk.size() == 0) begin
                            m_err = 1'b1;
                            m_pc++;
                        end else begin
                            m_pc = m_stk.pop_back();
                        end
                    end else begin
                        m_pc++;
                    end
                end
                2: begin
                    if (ins == 8'hBF) begin
                        m_halt = 1'b1;
                    end else begin
                        done = (src != 6 || (in_valid && e_ir)) &&
                               (dst != 6 || (e_ov && out_ready));
                        if (done) begin
                            if (dst < 6) m_r[dst] = v;
                            m_pc++;
                        end
                    end
                end
                default: begin
                    s = sx(m_r[3]);
                    case (dst)
                        0: take = 0;
                        1: take = (s == 0);
                        2: take = (s < 0);
                        3: take = (s <= 0);
                        4: take = 1;
                        5: take = (s != 0);
                        6: take = (s >= 0);
                        default: take = (s > 0);
                    endcase
                    m_pc = take ? (m_r[0] & PMASK) : m_pc + 1;
                end
            endcase
            m_pc &= PMASK;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        foreach (rom[k]) rom[k] = 8'h00;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int pcs [10];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clear_rom();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        check("rst_pc", 32'(prog_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(stack_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Arithmetic: r1=5, r2=10, ADD, then show r3
        clear_rom();
        rom[0] = 8'h05; rom[1] = 8'h81; rom[2] = 8'h0A;
        rom[3] = 8'h82; rom[4] = 8'h44; rom[5] = 8'h9E;
        restart();
        #1 check("first_fetch", 32'(prog_addr), 32'd0);
        repeat (5) tick();
        #1 check("arith_pc", 32'(prog_addr), 32'd5);
        out_ready = 1'b1;
        #1 check("arith_r3", 32'(out_data), 32'd15);
        tick();
        out_ready = 1'b0;

        // Input stall
        clear_rom();
        rom[0] = 8'hB0; rom[1] = 8'h86;
        restart();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_stall_rdy", 32'(in_ready), 32'd1);
            check("in_stall_pc", 32'(prog_addr), 32'd0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h7E;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("in_done_pc", 32'(prog_addr), 32'd1);
        check("in_done_r0", 32'(out_data), 32'h7E);
        tick();
        out_ready = 1'b0;

        // Output stall with pass-through
        clear_rom();
        rom[0] = 8'hB6;
        restart();
        xfers = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            tick();
        end
        in_valid  = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b1;
        #1;
        check("pass_in_ready", 32'(in_ready), 32'd1);
        check("pass_out_valid", 32'(out_valid), 32'd1);
        check("pass_data", 32'(out_data), 32'h33);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("pass_xfers", 32'(xfers), 32'd1);
        check("pass_pc", 32'(prog_addr), 32'd1);

        // Stack boundary with two entries
        clear_rom();
        rom[0]  = 8'h0A; rom[1]  = 8'h46; rom[2] = 8'h47; rom[3] = 8'hBF;
        rom[10] = 8'h14; rom[11] = 8'h46; rom[12] = 8'h47;
        rom[20] = 8'h1E; rom[21] = 8'h46; rom[22] = 8'h47;
        pcs = '{0, 1, 10, 11, 20, 21, 22, 12, 2, 3};
        restart();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stk_pc", 32'(prog_addr), 32'(pcs[i]));
            check("stk_err", 32'(stack_err), 32'(i >= 6));
            tick();
        end
        #1 check("stk_halt", 32'(halted), 32'd1);

        // Conditions, then HALT
        clear_rom();
        rom[0] = 8'h20; rom[1] = 8'h81; rom[2] = 8'h82; rom[3] = 8'h44;
        rom[4] = 8'h99; rom[5] = 8'h9A; rom[6] = 8'h44; rom[7] = 8'h28;
        rom[8] = 8'hC2; rom[40] = 8'hC7; rom[41] = 8'hBF;
        restart();
        repeat (8) tick();
        #1 check("cond_pre_pc", 32'(prog_addr), 32'd8);
        tick();
        #1 check("cond_neg_jump", 32'(prog_addr), 32'd40);
        tick();
        #1 check("cond_gt_fall", 32'(prog_addr), 32'd41);
        tick();
        repeat (10) tick();
        #1;
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(prog_addr), 32'd41);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("halt_rst_pc", 32'(prog_addr), 32'd0);
        check("halt_rst_flag", 32'(halted), 32'd0);

        // Reset while an output transfer is pending
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h86;
        restart();
        tick();
        tick();
        #1;
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_data", 32'(out_data), 32'd21);
        xfers     = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mid_rst_pc", 32'(prog_addr), 32'd0);
        check("mid_rst_xfers", 32'(xfers), 32'd0);

        // Random programs with random handshakes and occasional reset
        for (int p = 0; p < 6; p++) begin
            foreach (rom[k]) rom[k] = 8'($urandom);
            restart();
            for (int c = 0; c < 500; c++) begin
                in_valid  = 1'($urandom);
                in_data   = 8'($urandom);
                out_ready = 1'($urandom);
                rst       = ($urandom_range(0, 99) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/overture_stack_core.md
OVERTURE_STACK_CORE -- requirements
Module: overture_stack_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of registers, ALU and I/O data, range 8..32.
REQ-002 SHALL have parameter PC_WIDTH, default 8: program counter width, range 4..16.
REQ-003 SHALL have parameter STACK_DEPTH, default 4: number of return-address entries, range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port prog_addr, output, PC_WIDTH bits: equals the current PC.
REQ-007 SHALL have port prog_data, input, 8 bits: instruction at prog_addr, valid combinationally in the same cycle.
REQ-008 SHALL have port in_valid, input, 1 bit: the in_data word is available.
REQ-009 SHALL have port in_ready, output, 1 bit: the core is accepting in_data this cycle.
REQ-010 SHALL have port in_data, input, DATA_WIDTH bits: the input word.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the sink accepts out_data.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits: the output word; value is 0 when out_valid=0.
REQ-014 SHALL have port halted, output, 1 bit: the core has executed HALT.
REQ-015 SHALL have port stack_err, output, 1 bit: sticky flag for call-stack overflow or underflow.

Function
REQ-016 SHALL decode the instruction mode from prog_data[7:6]:
- 00 = IMM
- 01 = CALC
- 10 = COPY
- 11 = COND
REQ-017 SHALL execute IMM as r0 <= zero-extended prog_data[5:0].
REQ-018 SHALL execute CALC op prog_data[2:0] as r3 <= f(r1, r2), truncated to DATA_WIDTH:
- 0 = OR, 1 = NAND, 2 = NOR, 3 = AND
- 4 = ADD (modulo 2^DATA_WIDTH)
- 5 = SUB, r1-r2 (modulo 2^DATA_WIDTH)
REQ-019 SHALL treat CALC op 6 as CALL: push PC+1 onto the stack, then PC <= r0[PC_WIDTH-1:0].
REQ-020 SHALL treat CALC op 7 as RET: pop the stack into PC.
REQ-021 SHALL execute COPY as dst <= src, with src = prog_data[5:3] and dst = prog_data[2:0]:
- codes 0..5 = r0..r5
- code 6 = I/O
- src code 7 reads as 0
- dst code 7 is discarded
REQ-022 SHALL treat COPY with src=7 and dst=7 (opcode 0xBF) as HALT: set halted, freeze PC and all state until rst.
REQ-023 SHALL evaluate COND on r3 as a signed value, selected by prog_data[2:0]:
- 0 = never, 1 = ==0, 2 = <0, 3 = <=0
- 4 = always, 5 = !=0, 6 = >=0, 7 = >0
- condition true: PC <= r0[PC_WIDTH-1:0]
- condition false: PC <= PC+1
REQ-024 SHALL complete every non-stalled instruction in exactly one cycle; PC <= PC+1 modulo 2^PC_WIDTH unless REQ-019/020/023 set it otherwise.
REQ-025 SHALL assert in_ready combinationally only when all hold: COPY with src=6, not halted, rst low, and (dst!=6 or out_ready).
REQ-026 SHALL assert out_valid combinationally only when all hold: COPY with dst=6, not halted, rst low, and (src!=6 or in_valid).
REQ-027 SHALL drive out_data from the source of the COPY; for src=6 this is in_data (pass-through).
REQ-028 SHALL stall an I/O COPY until its handshake completes: PC, registers and stack hold while in_valid&in_ready or out_valid&out_ready is not yet true for every I/O side the instruction uses.
REQ-029 SHALL not depend on prior stall history: in_valid/out_ready may drop during a stall without side effects.
REQ-030 SHALL handle CALL with a full stack (STACK_DEPTH entries) as follows: no push, set stack_err, PC <= PC+1.
REQ-031 SHALL handle RET with an empty stack as follows: set stack_err, PC <= PC+1.
REQ-032 SHALL keep stack_err set until rst.
REQ-033 SHALL let a single CALL/RET at the boundary be exact: STACK_DEPTH nested CALLs succeed, and the (STACK_DEPTH+1)th CALL fails.
REQ-034 SHALL wrap PC from 2^PC_WIDTH-1 to 0; CALL pushes the wrapped PC+1.

Reset
REQ-035 SHALL, while rst=1 at a rising edge, set:
- PC = 0
- r0..r5 = 0
- stack pointer = 0 (empty)
- halted = 0
- stack_err = 0
REQ-036 SHALL force in_ready=0, out_valid=0 and out_data=0 while rst=1, including when rst is asserted mid-stall; the pending transfer is abandoned.
REQ-037 SHALL fetch prog_addr=0 on the first cycle after rst deasserts.

Verification
REQ-038 SHALL verify arithmetic: program 0x05, 0x81, 0x0A, 0x82, 0x44 (r1=5, r2=10, ADD), with DATA_WIDTH=8 -> r3=15 after 5 cycles, PC=5.
REQ-039 SHALL verify the input stall: COPY 0xB0 (in->r0) with in_valid=0 for 3 cycles, then in_data=0x7E -> in_ready high throughout, PC=0 for 3 cycles, r0=0x7E and PC=1 one cycle after in_valid rises.
REQ-040 SHALL verify the output stall and pass-through: 0xB6 with out_ready low 2 cycles, then in_valid=1 with 0x33 and out_ready=1 -> single transfer out_data=0x33, both handshakes in the same cycle, PC advances once.
REQ-041 SHALL verify the stack boundary with STACK_DEPTH=2:
- three nested CALLs -> third sets stack_err and continues at caller+1
- then two RETs -> return correctly
- third RET -> PC+1, stack_err remains 1
REQ-042 SHALL verify conditions and HALT: r3=0x80 with COND 0xC2 (<0) -> jump to r0; COND 0xC7 (>0) -> PC+1; then 0xBF -> halted=1, PC frozen 10 cycles, rst clears all.
REQ-043 SHALL verify reset mid-stall: rst during a pending out_valid -> out_valid=0 in that cycle, PC=0 next cycle, no transfer recorded.
